remote_req_queue: RTL
=====================

Name: remote_req_queue

Overview:
- Buffers remote requests produced by the load-store unit: remote loads, stores, atomics and icache-miss fetches.
- Presents them to the network TX endpoint with a valid/yumi handshake.
- Enforces the tile's outstanding-request credit limit.
- Sits between the EXE-stage address generation and the manycore endpoint; ready_o back-pressures EXE (stall).

Parameters:
- els_p, 2, queue depth in entries; integer >= 2.
- max_out_credits_p, 32, maximum outstanding remote requests (queued plus in flight).
- credit_width_lp, `BSG_SAFE_CLOG2(max_out_credits_p+1), localparam, credit counter width.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-low reset; state resets when reset_i==0 at posedge.
- v_i  input  1  request valid from LSU.
- remote_req_i  input  remote_req_s  request payload from LSU.
- ready_o  output  1  enqueue permitted this cycle.
- v_o  output  1  head entry valid to network TX.
- remote_req_o  output  remote_req_s  head entry payload.
- yumi_i  input  1  network TX consumes head this cycle.
- credit_return_i  input  1  one response or credit returned from network (pulse per credit).
- out_credits_o  output  credit_width_lp  currently available credits.
- empty_o  output  1  queue holds no entries.
- idle_o  output  1  empty_o and out_credits_o==max_out_credits_p (fence/barrier complete).

Behaviour:
- Storage: els_p-entry circular buffer with rptr, wptr and count, each of width clog2(els_p+1). Pointers wrap from els_p-1 to 0.
- Reset (reset_i==0 at posedge):
  - count=0, rptr=wptr=0, credits=max_out_credits_p.
  - Outputs: v_o=0, empty_o=1, idle_o=1.
  - ready_o is forced 0 combinationally while reset_i==0.
  - Any request or credit presented during reset is discarded.
- ready_o = reset_i & (count<els_p) & (credits!=0). Combinational; it does not depend on v_i or yumi_i.
- Enqueue occurs when v_i & ready_o:
  - writes remote_req_i at wptr, increments wptr and count, decrements credits.
  - v_i & ~ready_o has no effect; the upstream holds the request and stalls.
- Credit accounting:
  - A credit is reserved at enqueue, not at yumi. Queued plus in-flight requests therefore never exceed max_out_credits_p.
- v_o = (count!=0). remote_req_o = mem[rptr], registered storage, valid-then-yumi.
- Dequeue occurs when yumi_i:
  - increments rptr, decrements count.
  - yumi_i while v_o==0 is illegal (assertion error).
- Latency: a request enqueued into an empty queue appears on v_o at the next posedge (1 cycle).
- Simultaneous enqueue and dequeue:
  - count is unchanged and both pointers advance.
  - This is allowed when full, but ready_o is still 0 when full. Full plus yumi does not enable a same-cycle enqueue; no combinational yumi-to-ready path.
- Simultaneous enqueue and credit_return_i: credits unchanged.
- credit_return_i alone: credits+1.
- credit_return_i when credits==max_out_credits_p is illegal: assertion error, and credits saturate at max.
- credits==0 with entries still queued: draining continues normally; only enqueue is blocked.
- Icache-fetch requests consume credits identically to data requests.
- Order is strictly FIFO; no reordering between loads, stores and amos.
- Assertions (translate_off, negedge, only when reset_i==1): yumi_i & ~v_o; credit overflow.

Optional Feature:
- Macro: REMOTE_REQ_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and v_i & ready_o, the request is driven combinationally on v_o/remote_req_o in the same cycle.
  - If yumi_i is asserted that cycle, the request is not written into storage. Credits are still decremented and pointers are unchanged.
  - If yumi_i is not asserted, it is enqueued normally.
  - Zero-cycle latency in the empty case.
- Undefined: v_o depends only on stored state; minimum latency is 1 cycle as above.

Test Plan:
- Reset, then v_i=1 with addr=0x8000_0100, store, yumi_i=0 -> next cycle v_o=1, remote_req_o.addr=0x8000_0100, out_credits_o=31, idle_o=0.
- els_p=2: enqueue 3 back-to-back with no yumi -> ready_o=0 after the 2nd; 3rd is held. Then assert yumi -> head order A,B; C enqueues the cycle after ready_o rises.
- max_out_credits_p=4: enqueue and consume 4 with no credit_return_i -> ready_o=0 with empty_o=1. One credit_return_i pulse -> out_credits_o=1, ready_o=1.
- Same cycle, enqueue plus yumi plus credit_return_i with count=1, credits=3 -> count stays 1, credits stay 3, head advances.
- Drive reset_i=0 with count=2 and credits=10 -> next cycle v_o=0, out_credits_o=32, ready_o=0 during reset, 1 after release.
- With BYPASS_EN, empty queue, v_i=1 and yumi_i=1 same cycle -> v_o=1 that cycle, payload matches remote_req_i, count stays 0, credits=31. Without the macro, v_o=0 that cycle.

Source files
------------

// File: rtl/remote_req_queue_if.sv
// ----------------------------------------------------------------------------
// remote_req_queue_if: request payload type and LSU/network-side bundle of
// remote_req_queue.                                          Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package remote_req_queue_pkg;

  typedef enum logic [1:0] {
    REQ_LOAD   = 2'd0,
    REQ_STORE  = 2'd1,
    REQ_AMO    = 2'd2,
    REQ_IFETCH = 2'd3
  } req_op_e;

  typedef struct packed {
    req_op_e     op;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
  } remote_req_s;

endpackage

interface remote_req_queue_if #(
  parameter int max_out_credits_p = 32
);
  localparam int credit_width_lp =
    ((max_out_credits_p + 1) == 1) ? 1 : $clog2(max_out_credits_p + 1);

  logic                              v_i;
  remote_req_queue_pkg::remote_req_s remote_req_i;
  logic                              ready_o;
  logic                              v_o;
  remote_req_queue_pkg::remote_req_s remote_req_o;
  logic                              yumi_i;
  logic                              credit_return_i;
  logic [credit_width_lp-1:0]        out_credits_o;
  logic                              empty_o;
  logic                              idle_o;

  modport slave (
    input  v_i, remote_req_i, yumi_i, credit_return_i,
    output ready_o, v_o, remote_req_o, out_credits_o, empty_o, idle_o
  );

  modport master (
    output v_i, remote_req_i, yumi_i, credit_return_i,
    input  ready_o, v_o, remote_req_o, out_credits_o, empty_o, idle_o
  );

endinterface

`default_nettype wire

// File: rtl/remote_req_queue.sv
// ----------------------------------------------------------------------------
// remote_req_queue: credit-limited FIFO of LSU remote requests toward network
// TX. Define REMOTE_REQ_QUEUE_BYPASS_EN for zero-latency empty-queue bypass.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module remote_req_queue #(
  parameter int els_p             = 2,
  parameter int max_out_credits_p = 32
) (
  input wire                clk_i,
  input wire                reset_i,
  remote_req_queue_if.slave q
);

  localparam int credit_width_lp =
    ((max_out_credits_p + 1) == 1) ? 1 : $clog2(max_out_credits_p + 1);
  localparam int c_ptr_w = $clog2(els_p + 1);
  localparam int c_idx_w = $clog2(els_p);

  localparam logic [c_ptr_w-1:0]         c_els         = c_ptr_w'(els_p);
  localparam logic [c_ptr_w-1:0]         c_last        = c_ptr_w'(els_p - 1);
  localparam logic [credit_width_lp-1:0] c_max_credits = credit_width_lp'(max_out_credits_p);

  remote_req_queue_pkg::remote_req_s r_mem [els_p];
  logic [c_ptr_w-1:0]                r_rptr;
  logic [c_ptr_w-1:0]                r_wptr;
  logic [c_ptr_w-1:0]                r_count;
  logic [credit_width_lp-1:0]        r_credits;

  logic                              w_stored_v;
  logic                              w_ready;
  logic                              w_enq;
  logic                              w_write;
  logic                              w_deq;
  remote_req_queue_pkg::remote_req_s w_head;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_stored_v = (r_count != '0);
  // Ready looks only at stored state so there is no yumi-to-ready path.
  assign w_ready    = reset_i & (r_count < c_els) & (r_credits != '0);
  assign w_enq      = q.v_i & w_ready;
  assign w_deq      = q.yumi_i & w_stored_v;
  assign w_head     = r_mem[r_rptr[c_idx_w-1:0]];

`ifdef REMOTE_REQ_QUEUE_BYPASS_EN
  logic w_bypass;

  // An empty queue forwards the incoming request; if taken now it is never stored.
  assign w_bypass       = w_enq & ~w_stored_v;
  assign w_write        = w_enq & ~(w_bypass & q.yumi_i);
  assign q.v_o          = w_stored_v | w_bypass;
  assign q.remote_req_o = w_stored_v ? w_head : q.remote_req_i;
`else
  assign w_write        = w_enq;
  assign q.v_o          = w_stored_v;
  assign q.remote_req_o = w_head;
`endif

  assign q.ready_o       = w_ready;
  assign q.out_credits_o = r_credits;
  assign q.empty_o       = ~w_stored_v;
  assign q.idle_o        = ~w_stored_v & (r_credits == c_max_credits);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_credits <= c_max_credits;
    end else begin
      if (w_write) begin
        r_wptr <= next_ptr(r_wptr);
      end
      if (w_deq) begin
        r_rptr <= next_ptr(r_rptr);
      end
      if (w_write && !w_deq) begin
        r_count <= r_count + c_ptr_w'(1);
      end else if (!w_write && w_deq) begin
        r_count <= r_count - c_ptr_w'(1);
      end
      // Credit is taken at enqueue; a same-cycle return cancels it out.
      if (w_enq && !q.credit_return_i) begin
        r_credits <= r_credits - credit_width_lp'(1);
      end else if (!w_enq && q.credit_return_i && (r_credits != c_max_credits)) begin
        r_credits <= r_credits + credit_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wptr[c_idx_w-1:0]] <= q.remote_req_i;
    end
  end

`ifndef SYNTHESIS
  always @(negedge clk_i) begin
    if (reset_i) begin
      assert (!(q.yumi_i && !q.v_o))
        else $error("remote_req_queue: yumi_i with no valid head");
      assert (!(q.credit_return_i && !w_enq && (r_credits == c_max_credits)))
        else $error("remote_req_queue: credit return overflows max_out_credits_p");
    end
  end
`endif

endmodule

`default_nettype wire
